multi_channel_event_sync: RTL and testbench

Parametrised, multi-channel successor to the single-bit toggle pulse synchroniser. Each of CH asynchronous inputs (toggle-encoded or level signals from foreign domains) is synchronised into `clk` through a configurable-depth flop chain, edge-decoded per a run-time mode, and turned into a one-cycle pulse plus a sticky pending flag, saturating event counter and overflow flag, all cleared by a per-channel ack. It sits at the destination side of every clock-domain crossing carrying sparse events (frame starts, DMA done, config strobes) and feeds interrupt/status logic.

---
 rtl/event_sync_pkg.sv | 17 +
 rtl/event_sync_channel.sv | 94 +++++++++
 rtl/multi_channel_event_sync.sv | 79 +++++++
 tb/tb_multi_channel_event_sync.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_sync_pkg.sv
// Shared encodings for the multi-channel event synchroniser: per-channel
// edge-decode modes and the block-level warm-up state.
package event_sync_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_RISE   = 2'b01,
    MODE_FALL   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } warm_state_e;

endpackage

// File: rtl/event_sync_channel.sv
// One channel: synchroniser chain, history flop, mode-qualified edge decode,
// and the pulse / pending / saturating counter / overflow status set.
module event_sync_channel
  import event_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_in,
  input  logic [1:0]       mode,
  input  logic             ack,
  input  logic             run,
  output logic             event_pulse,
  output logic             pending,
  output logic [CNT_W-1:0] event_cnt,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   pulse_q, pulse_d;
  logic                   pend_q, pend_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic  sync_last;
  logic  rise;
  logic  fall;
  logic  hit;
  mode_e mode_s;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign mode_s    = mode_e'(mode);

  always_comb begin
    // synchroniser and history always run, even in OFF, so re-enabling a
    // channel never sees a stale level difference as an edge
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    hist_d  = sync_last;
    rise    = sync_last & ~hist_q;
    fall    = ~sync_last & hist_q;

    hit = 1'b0;
    case (mode_s)
      MODE_TOGGLE: hit = rise | fall;
      MODE_RISE:   hit = rise;
      MODE_FALL:   hit = fall;
      default:     hit = 1'b0;
    endcase
    hit = hit & run;

    // ack clears first; an event in the same cycle is then applied on top
    pend_d  = ack ? 1'b0 : pend_q;
    cnt_d   = ack ? '0 : cnt_q;
    ovf_d   = ack ? 1'b0 : ovf_q;
    pulse_d = hit;
    if (hit) begin
      pend_d = 1'b1;
      if (cnt_d == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign event_pulse = pulse_q;
  assign pending     = pend_q;
  assign event_cnt   = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: rtl/multi_channel_event_sync.sv
// Multi-channel destination-side event synchroniser: warm-up FSM, per-channel
// instances, port slicing and the combined interrupt.
module multi_channel_event_sync
  import event_sync_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       async_in,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       ack,
  output logic [CH-1:0]       event_pulse,
  output logic [CH-1:0]       pending,
  output logic [CH*CNT_W-1:0] event_cnt,
  output logic [CH-1:0]       overflow,
  output logic                irq
);

  localparam int WCNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(SYNC_STAGES);

  warm_state_e       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              run;

  // Hold off edge detection for SYNC_STAGES+1 cycles so a level that was
  // already high at reset release is absorbed into history, not reported.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_WARMUP: begin
        if (wcnt_q == WARM_LAST) begin
          state_d = ST_RUN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_WARMUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WARMUP;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign run = (state_q == ST_RUN);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    event_sync_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (async_in[i]),
      .mode       (mode[2*i +: 2]),
      .ack        (ack[i]),
      .run        (run),
      .event_pulse(event_pulse[i]),
      .pending    (pending[i]),
      .event_cnt  (event_cnt[CNT_W*i +: CNT_W]),
      .overflow   (overflow[i])
    );
  end

  assign irq = |pending;

endmodule

// File: tb/tb_multi_channel_event_sync.sv
// Bench for multi_channel_event_sync: vector table, directed corner-case
// sequences, then random stimulus against a delay-line reference model.
module tb_multi_channel_event_sync;

  localparam int CH   = 4;
  localparam int S    = 3;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     async_in;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     ack;
  logic [CH-1:0]     event_pulse;
  logic [CH-1:0]     pending;
  logic [CH*CW-1:0]  event_cnt;
  logic [CH-1:0]     overflow;
  logic              irq;

  multi_channel_event_sync #(.CH(CH), .SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .mode(mode), .ack(ack),
    .event_pulse(event_pulse), .pending(pending), .event_cnt(event_cnt),
    .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [CH-1:0]   drv_ain;
  logic [CH-1:0]   drv_ack;
  logic [2*CH-1:0] drv_mode;

  // reference model: an event at edge n is decided by the input samples
  // taken S and S+1 edges earlier, provided the warm-up window has elapsed
  int            n_edge;
  logic          hist [CH][S+2];
  logic [CH-1:0] m_pulse, m_pend, m_ovf;
  int            m_cnt [CH];

  typedef struct {
    logic [3:0] ain;
    logic [3:0] ak;
    logic [3:0] pulse;
    logic [3:0] pend;
    int         cnt3;
  } vec_t;
  vec_t tbl [21];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int cnt_of(input int c);
    return int'(event_cnt[c*CW +: CW]);
  endfunction

  task automatic model_reset();
    n_edge = 0;
    m_pulse = '0; m_pend = '0; m_ovf = '0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0;
      for (int j = 0; j < S + 2; j++) hist[c][j] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic cur, prv, hit;
    int   md;
    n_edge++;
    for (int c = 0; c < CH; c++) begin
      for (int j = S + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = drv_ain[c];
      cur = hist[c][S];
      prv = hist[c][S+1];
      md  = int'(drv_mode[2*c +: 2]);
      hit = (n_edge >= S + 2) &&
            ((md == 0 && cur != prv) || (md == 1 && cur && !prv) ||
             (md == 2 && !cur && prv));
      if (drv_ack[c]) begin
        m_pend[c] = 1'b0; m_ovf[c] = 1'b0; m_cnt[c] = 0;
      end
      m_pulse[c] = hit;
      if (hit) begin
        m_pend[c] = 1'b1;
        if (m_cnt[c] == MAXC) m_ovf[c] = 1'b1;
        else m_cnt[c] = m_cnt[c] + 1;
      end
    end
  endtask

  task automatic step();
    async_in = drv_ain;
    mode     = drv_mode;
    ack      = drv_ack;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulse"}, int'(event_pulse), 0);
    chk({tag, "_pend"},  int'(pending), 0);
    chk({tag, "_cnt"},   int'(event_cnt), 0);
    chk({tag, "_ovf"},   int'(overflow), 0);
    chk({tag, "_irq"},   int'(irq), 0);
  endtask

  task automatic cmp_model();
    logic [CH*CW-1:0] exp_cnt;
    for (int c = 0; c < CH; c++) exp_cnt[c*CW +: CW] = CW'(m_cnt[c]);
    chk("rnd_pulse", int'(event_pulse), int'(m_pulse));
    chk("rnd_pend",  int'(pending),     int'(m_pend));
    chk("rnd_cnt",   int'(event_cnt),   int'(exp_cnt));
    chk("rnd_ovf",   int'(overflow),    int'(m_ovf));
    chk("rnd_irq",   int'(irq),         int'(|m_pend));
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int np, pj;
    int held [CH];

    // ch3 goes low/high twice under RISE; the second rise coincides with ack
    for (int i = 0; i < 21; i++)
      tbl[i] = '{ain: 4'hF, ak: 4'h0, pulse: 4'h0, pend: 4'h0, cnt3: 0};
    tbl[8].ain  = 4'h7; tbl[9].ain  = 4'h7;
    tbl[12].ain = 4'h7; tbl[13].ain = 4'h7;
    tbl[13].pulse = 4'h8; tbl[13].pend = 4'h8; tbl[13].cnt3 = 1;
    for (int i = 14; i < 17; i++) begin tbl[i].pend = 4'h8; tbl[i].cnt3 = 1; end
    tbl[17].ak = 4'h8; tbl[17].pulse = 4'h8; tbl[17].pend = 4'h8; tbl[17].cnt3 = 1;
    tbl[18].pend = 4'h8; tbl[18].cnt3 = 1;
    tbl[19].ak = 4'h8;

    // reset with all inputs high and every channel in RISE
    drv_ain = 4'hF; drv_mode = 8'h55; drv_ack = 4'h0;
    async_in = drv_ain; mode = drv_mode; ack = drv_ack;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    model_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drv_ain = tbl[i].ain;
      drv_ack = tbl[i].ak;
      step();
      chk($sformatf("tbl%0d_pulse", i), int'(event_pulse), int'(tbl[i].pulse));
      chk($sformatf("tbl%0d_pend", i),  int'(pending),     int'(tbl[i].pend));
      chk($sformatf("tbl%0d_cnt3", i),  cnt_of(3),         tbl[i].cnt3);
      chk($sformatf("tbl%0d_ovf", i),   int'(overflow),    0);
      chk($sformatf("tbl%0d_irq", i),   int'(irq),         int'(|tbl[i].pend));
    end
    drv_ack = 4'h0;

    // ch0 TOGGLE: three toggles four cycles apart, pulse S cycles after capture
    drv_mode[1:0] = 2'b00;
    for (int t = 0; t < 3; t++) begin
      drv_ain[0] = ~drv_ain[0];
      for (int k = 0; k < 4; k++) begin
        step();
        chk($sformatf("tog%0d_k%0d_pulse0", t, k), int'(event_pulse[0]), (k == 3) ? 1 : 0);
      end
    end
    chk("tog_cnt0", cnt_of(0), 3);
    chk("tog_pend0", int'(pending[0]), 1);
    chk("tog_ovf0", int'(overflow[0]), 0);

    // ch1 FALL: park low while OFF, then a 5-cycle high pulse
    drv_mode[3:2] = 2'b11; drv_ain[1] = 1'b0;
    np = 0;
    repeat (6) begin step(); if (event_pulse[1]) np++; end
    chk("fall_off_pulses", np, 0);
    drv_mode[3:2] = 2'b10;
    repeat (3) step();
    np = 0; pj = -1;
    for (int j = 0; j < 14; j++) begin
      drv_ain[1] = (j < 5);
      step();
      if (event_pulse[1]) begin np++; pj = j; end
    end
    chk("fall_pulses", np, 1);
    chk("fall_pulse_pos", pj, 5 + S);
    chk("fall_cnt1", cnt_of(1), 1);

    // ch2 RISE: counter saturation then overflow on the fourth edge
    for (int i = 0; i < 3; i++) begin
      drv_ain[2] = 1'b0; repeat (3) step();
      drv_ain[2] = 1'b1; repeat (3) step();
    end
    repeat (4) step();
    chk("sat3_cnt2", cnt_of(2), 3);
    chk("sat3_ovf2", int'(overflow[2]), 0);
    drv_ain[2] = 1'b0; repeat (3) step();
    drv_ain[2] = 1'b1; repeat (7) step();
    chk("sat4_cnt2", cnt_of(2), 3);
    chk("sat4_ovf2", int'(overflow[2]), 1);
    chk("sat4_pend2", int'(pending[2]), 1);
    drv_ack[2] = 1'b1; step(); drv_ack[2] = 1'b0;
    chk("ack2_cnt", cnt_of(2), 0);
    chk("ack2_ovf", int'(overflow[2]), 0);
    chk("ack2_pend", int'(pending[2]), 0);

    // ch0 OFF: toggles ignored and status held, ack still clears
    drv_mode[1:0] = 2'b11;
    np = 0;
    repeat (2) begin
      drv_ain[0] = ~drv_ain[0];
      repeat (4) begin step(); if (event_pulse[0]) np++; end
    end
    chk("off_pulses", np, 0);
    chk("off_cnt0", cnt_of(0), 3);
    chk("off_pend0", int'(pending[0]), 1);
    drv_ack[0] = 1'b1; step(); drv_ack[0] = 1'b0;
    chk("off_ack_cnt0", cnt_of(0), 0);
    chk("off_ack_pend0", int'(pending[0]), 0);
    drv_mode[1:0] = 2'b00;
    np = 0;
    repeat (5) begin step(); if (event_pulse[0]) np++; end
    chk("reenable_no_false_edge", np, 0);
    drv_ain[0] = ~drv_ain[0];
    repeat (6) begin step(); if (event_pulse[0]) np++; end
    chk("reenable_pulses", np, 1);
    chk("reenable_cnt0", cnt_of(0), 1);
    chk("irq_set", int'(irq), 1);
    drv_ack = 4'hF; step(); drv_ack = 4'h0;
    chk("irq_clear", int'(irq), 0);

    // asynchronous reset mid-cycle
    drv_ain[3] = 1'b0; drv_ain[0] = ~drv_ain[0];
    step(); step();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // random phase against the reference model
    for (int c = 0; c < CH; c++) held[c] = 2;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        held[c]++;
        if (held[c] >= 2 && $urandom_range(0, 2) == 0) begin
          drv_ain[c] = ~drv_ain[c];
          held[c] = 0;
        end
        drv_ack[c] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 49) == 0)
        drv_mode[2*$urandom_range(0, CH-1) +: 2] = 2'($urandom_range(0, 3));
      step();
      cmp_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
